line_buffer_ctrl: RTL and testbench
===================================

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512, pixels per image line; counter widths derived from it.
REQ-002 SHALL have parameter NUM_LB, fixed at 4, number of line buffers sequenced.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 inPixelValid  input  1  upstream pixel offered this cycle.
REQ-006 outSpaceAvail  input  1  downstream output FIFO can accept a convolved pixel this cycle.
REQ-007 inPixelReady  output  1  controller can accept an incoming pixel.
REQ-008 lbWrEn  output  4  one-hot write enable to line buffers 0..3.
REQ-009 lbRdEn  output  4  read/advance enable to the three active line buffers.
REQ-010 rdSel  output  2  index of the oldest of the three rows feeding the 3x3 kernel mux.
REQ-011 pixelDataValid  output  1  kernel window valid this cycle.
REQ-012 interrupt  output  1  one-cycle pulse: one line consumed, one buffer free.

Function
REQ-013 SHALL accept a write when inPixelValid && inPixelReady; lbWrEn = one-hot(wrLineSel) on that cycle, else 0.
REQ-014 SHALL count accepted writes in wrPixCnt; at IMG_WIDTH-1 it wraps to 0 and wrLineSel increments modulo 4 (3 -> 0).
REQ-015 SHALL keep totalPixCnt (0..4*IMG_WIDTH): +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-016 inPixelReady SHALL be 1 when totalPixCnt < 4*IMG_WIDTH or a read occurs this cycle; an offer while not ready SHALL be dropped with no state change.
REQ-017 Read FSM states: IDLE, RD_BUSY.
REQ-018 IDLE -> RD_BUSY when totalPixCnt >= 3*IMG_WIDTH and outSpaceAvail; no reads occur in IDLE.
REQ-019 rdActive = (state == RD_BUSY) && outSpaceAvail; pixelDataValid = rdActive (combinational, line buffers prefetch).
REQ-020 lbRdEn SHALL be one-hot bits rdLineSel, rdLineSel+1, rdLineSel+2 (mod 4) when rdActive, else 0; rdSel = rdLineSel.
REQ-021 rdPixCnt SHALL increment on rdActive; when rdActive at IMG_WIDTH-1 it wraps to 0, rdLineSel increments mod 4, FSM returns to IDLE.
REQ-022 interrupt SHALL be registered, high exactly one cycle, on the cycle after the final read of a line.
REQ-023 outSpaceAvail low in RD_BUSY SHALL stall: rdPixCnt, rdLineSel and FSM hold, lbRdEn = 0.
REQ-024 A read line SHALL always contain exactly IMG_WIDTH rdActive cycles regardless of stalls.

Reset
REQ-025 rst low SHALL immediately clear state to IDLE and all counters, wrLineSel, rdLineSel to 0.
REQ-026 During reset lbWrEn = 0, lbRdEn = 0, rdSel = 0, pixelDataValid = 0, interrupt = 0, inPixelReady = 1 after release.
REQ-027 Reset mid-line SHALL discard partial write and read progress; no interrupt is generated for it.

Configuration
REQ-028 Macro LBC_STATUS_EN defined: adds outputs lineCount [2:0] = totalPixCnt / IMG_WIDTH and dropErr [0:0], sticky, set when inPixelValid && !inPixelReady, cleared only by reset.
REQ-029 Macro LBC_STATUS_EN undefined: those ports and their logic are absent; all other behaviour identical.

Verification (IMG_WIDTH = 512)
REQ-030 Reset, 1536 back-to-back valid pixels, outSpaceAvail = 1 -> lbWrEn 0001/0010/0100 for 512 pixels each; RD_BUSY entered; lbRdEn = 0111, rdSel = 0 for 512 cycles; one interrupt pulse; rdLineSel = 1.
REQ-031 2049 pixels, outSpaceAvail = 0 -> inPixelReady drops after pixel 2048; pixel 2049 gives no lbWrEn; dropErr = 1 and lineCount = 4 with LBC_STATUS_EN.
REQ-032 Steady stream after two lines consumed (rdLineSel = 2), concurrent write and read -> lbRdEn = 1101, totalPixCnt unchanged per cycle, wrLineSel wraps 3 -> 0.
REQ-033 outSpaceAvail low for 10 cycles at rdPixCnt = 100 -> lbRdEn = 0 and pixelDataValid = 0 for those cycles; exactly 512 valid cycles before interrupt.
REQ-034 rst low at rdPixCnt = 300 -> all outputs 0 immediately; after release, 1536 new pixels restart at buffer 0 with no spurious interrupt.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences writes into four line buffers and reads three of
// them at a time to feed a 3x3 convolution kernel.
// Optional status outputs (lineCount, dropErr) exist only when the macro
// LBC_STATUS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for three full lines and downstream space; no reads
// RD_BUSY | streaming one line out of the three active buffers
module line_buffer_ctrl #(
  parameter int IMG_WIDTH = 512,
  parameter int NUM_LB    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inPixelValid,
  input  logic              outSpaceAvail,
  output logic              inPixelReady,
  output logic [NUM_LB-1:0] lbWrEn,
  output logic [NUM_LB-1:0] lbRdEn,
  output logic [1:0]        rdSel,
  output logic              pixelDataValid,
`ifdef LBC_STATUS_EN
  output logic [2:0]        lineCount,
  output logic [0:0]        dropErr,
`endif
  output logic              interrupt
);

  localparam int PIX_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int TOT_W = $clog2(NUM_LB * IMG_WIDTH + 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(IMG_WIDTH - 1);
  localparam logic [TOT_W-1:0] TOT_FULL  = TOT_W'(NUM_LB * IMG_WIDTH);
  localparam logic [TOT_W-1:0] TOT_READY = TOT_W'(3 * IMG_WIDTH);

  typedef enum logic {IDLE, RD_BUSY} state_t;

  state_t           state;
  logic [PIX_W-1:0] wrPixCnt;
  logic [PIX_W-1:0] rdPixCnt;
  logic [1:0]       wrLineSel;
  logic [1:0]       rdLineSel;
  logic [1:0]       rdSkip;
  logic [TOT_W-1:0] totalPixCnt;
  logic             wrAccept;
  logic             rdActive;

  // A read in the same cycle frees a slot, so a full buffer set can still
  // take a pixel while it is being drained.
  assign rdActive       = (state == RD_BUSY) && outSpaceAvail;
  assign inPixelReady   = (totalPixCnt < TOT_FULL) || rdActive;
  assign wrAccept       = inPixelValid && inPixelReady;
  assign pixelDataValid = rdActive;
  assign rdSel          = rdLineSel;

  // The three active rows are every buffer except the one three ahead of the
  // oldest row (that one is being refilled).
  assign rdSkip = rdLineSel + 2'd3;

  // Output enables; write enable is masked while reset is asserted.
  always_comb begin
    lbWrEn = '0;
    lbRdEn = '0;
    if (wrAccept && rst) lbWrEn = NUM_LB'(1) << wrLineSel;
    if (rdActive)        lbRdEn = ~(NUM_LB'(1) << rdSkip);
  end

  // Write-side pixel and line position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPixCnt  <= '0;
      wrLineSel <= 2'd0;
    end else if (wrAccept) begin
      if (wrPixCnt == PIX_LAST) begin
        wrPixCnt  <= '0;
        wrLineSel <= wrLineSel + 2'd1;
      end else begin
        wrPixCnt <= wrPixCnt + PIX_W'(1);
      end
    end
  end

  // Occupancy across all buffers: written but not yet consumed pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      totalPixCnt <= '0;
    end else begin
      case ({wrAccept, rdActive})
        2'b10:   totalPixCnt <= totalPixCnt + TOT_W'(1);
        2'b01:   totalPixCnt <= totalPixCnt - TOT_W'(1);
        default: totalPixCnt <= totalPixCnt;
      endcase
    end
  end

  // Read FSM with read position, line select and end-of-line pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rdPixCnt  <= '0;
      rdLineSel <= 2'd0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= 1'b0;
      case (state)
        IDLE: begin
          if ((totalPixCnt >= TOT_READY) && outSpaceAvail) state <= RD_BUSY;
        end
        RD_BUSY: begin
          if (outSpaceAvail) begin
            if (rdPixCnt == PIX_LAST) begin
              rdPixCnt  <= '0;
              rdLineSel <= rdLineSel + 2'd1;
              state     <= IDLE;
              interrupt <= 1'b1;
            end else begin
              rdPixCnt <= rdPixCnt + PIX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LBC_STATUS_EN
  assign lineCount = 3'(totalPixCnt / TOT_W'(IMG_WIDTH));

  // Sticky flag for any pixel offered while the buffers were full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropErr <= 1'b0;
    end else if (inPixelValid && !inPixelReady) begin
      dropErr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with IMG_WIDTH = 512: a short vector table,
// directed multi-cycle sequences and randomized traffic, all checked against
// a pixel-count reference model.
module tb_line_buffer_ctrl;
  localparam int W = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inPixelValid = 1'b0;
  logic       outSpaceAvail = 1'b0;
  logic       inPixelReady;
  logic [3:0] lbWrEn;
  logic [3:0] lbRdEn;
  logic [1:0] rdSel;
  logic       pixelDataValid;
  logic       interrupt;
`ifdef LBC_STATUS_EN
  logic [2:0] lineCount;
  logic [0:0] dropErr;
`endif

  line_buffer_ctrl #(.IMG_WIDTH(W), .NUM_LB(4)) dut (
    .clk(clk),
    .rst(rst),
    .inPixelValid(inPixelValid),
    .outSpaceAvail(outSpaceAvail),
    .inPixelReady(inPixelReady),
    .lbWrEn(lbWrEn),
    .lbRdEn(lbRdEn),
    .rdSel(rdSel),
    .pixelDataValid(pixelDataValid),
`ifdef LBC_STATUS_EN
    .lineCount(lineCount),
    .dropErr(dropErr),
`endif
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: total pixels ever written / read since reset.
  int m_wr, m_rd, m_busy, m_int, m_drop;

  // Scenario observation counters.
  int n_wrb[4];
  int n_rd0111, n_rd1101, n_pdv, n_int;

  typedef struct {
    logic       rst_v;
    logic       iv;
    logic       osa;
    logic [3:0] wr;
    logic [3:0] rd;
    logic       pdv;
    logic       rdy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) n_wrb[i] = 0;
    n_rd0111 = 0; n_rd1101 = 0; n_pdv = 0; n_int = 0;
  endtask

  // Asynchronous reset: outputs must clear at once, even with a pixel offered.
  task automatic do_reset();
    rst = 1'b0;
    inPixelValid = 1'b1;
    outSpaceAvail = 1'b1;
    #1;
    chk("rst_lbWrEn", lbWrEn, 0);
    chk("rst_lbRdEn", lbRdEn, 0);
    chk("rst_rdSel", rdSel, 0);
    chk("rst_pixelDataValid", pixelDataValid, 0);
    chk("rst_interrupt", interrupt, 0);
    m_wr = 0; m_rd = 0; m_busy = 0; m_int = 0; m_drop = 0;
    inPixelValid = 1'b0;
    outSpaceAvail = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic cycle(input logic iv, input logic osa);
    int tot, rsel, wsel;
    bit rd, rdy, wr, eol;
    logic [3:0] e_wr, e_rd;
    inPixelValid = iv;
    outSpaceAvail = osa;
    tot  = m_wr - m_rd;
    rsel = (m_rd / W) % 4;
    wsel = (m_wr / W) % 4;
    rd   = (m_busy != 0) && osa;
    rdy  = (tot < 4 * W) || rd;
    wr   = iv && rdy;
    e_wr = wr ? 4'(1 << wsel) : 4'b0000;
    e_rd = 4'b0000;
    if (rd) for (int k = 0; k < 3; k++) e_rd[(rsel + k) % 4] = 1'b1;
    @(negedge clk);
    chk("lbWrEn", lbWrEn, e_wr);
    chk("lbRdEn", lbRdEn, e_rd);
    chk("rdSel", rdSel, rsel);
    chk("pixelDataValid", pixelDataValid, rd);
    chk("interrupt", interrupt, m_int);
    chk("inPixelReady", inPixelReady, rdy);
`ifdef LBC_STATUS_EN
    chk("lineCount", lineCount, tot / W);
    chk("dropErr", dropErr, m_drop);
`endif
    for (int b = 0; b < 4; b++) if (lbWrEn == 4'(1 << b)) n_wrb[b]++;
    if (lbRdEn == 4'b0111) n_rd0111++;
    if (lbRdEn == 4'b1101) n_rd1101++;
    if (pixelDataValid) n_pdv++;
    if (interrupt) n_int++;
    @(posedge clk);
    #1;
    if (iv && !rdy) m_drop = 1;
    m_wr += int'(wr);
    m_rd += int'(rd);
    eol   = rd && (m_rd % W == 0);
    m_int = int'(eol);
    if (m_busy == 0 && tot >= 3 * W && osa) m_busy = 1;
    else if (eol) m_busy = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int pdv_before;

    vecs[0] = '{rst_v: 1'b0, iv: 1'b1, osa: 1'b1, wr: 4'b0000, rd: 4'b0000, pdv: 1'b0, rdy: 1'b1};
    vecs[1] = '{rst_v: 1'b1, iv: 1'b0, osa: 1'b0, wr: 4'b0000, rd: 4'b0000, pdv: 1'b0, rdy: 1'b1};
    vecs[2] = '{rst_v: 1'b1, iv: 1'b1, osa: 1'b0, wr: 4'b0001, rd: 4'b0000, pdv: 1'b0, rdy: 1'b1};
    vecs[3] = '{rst_v: 1'b1, iv: 1'b1, osa: 1'b1, wr: 4'b0001, rd: 4'b0000, pdv: 1'b0, rdy: 1'b1};
    vecs[4] = '{rst_v: 1'b1, iv: 1'b0, osa: 1'b1, wr: 4'b0000, rd: 4'b0000, pdv: 1'b0, rdy: 1'b1};
    vecs[5] = '{rst_v: 1'b0, iv: 1'b1, osa: 1'b1, wr: 4'b0000, rd: 4'b0000, pdv: 1'b0, rdy: 1'b1};

    clear_counts();
    do_reset();

    // Vector table: reset masking and first writes into buffer 0.
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst_v;
      inPixelValid = vecs[i].iv;
      outSpaceAvail = vecs[i].osa;
      @(negedge clk);
      chk($sformatf("vec%0d_lbWrEn", i), lbWrEn, vecs[i].wr);
      chk($sformatf("vec%0d_lbRdEn", i), lbRdEn, vecs[i].rd);
      chk($sformatf("vec%0d_pdv", i), pixelDataValid, vecs[i].pdv);
      chk($sformatf("vec%0d_ready", i), inPixelReady, vecs[i].rdy);
      @(posedge clk);
      #1;
    end

    // Three lines in, one line read out.
    do_reset();
    clear_counts();
    for (int i = 0; i < 3 * W; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 600; i++) cycle(1'b0, 1'b1);
    chk("fill_buf0", n_wrb[0], W);
    chk("fill_buf1", n_wrb[1], W);
    chk("fill_buf2", n_wrb[2], W);
    chk("fill_buf3", n_wrb[3], 0);
    chk("read_0111", n_rd0111, W);
    chk("read_pdv", n_pdv, W);
    chk("read_irq", n_int, 1);
    chk("read_rdSel_after", rdSel, 1);

    // Overfill with no downstream space.
    do_reset();
    clear_counts();
    for (int i = 0; i < 4 * W + 1; i++) cycle(1'b1, 1'b0);
    chk("full_writes", n_wrb[0] + n_wrb[1] + n_wrb[2] + n_wrb[3], 4 * W);
    chk("full_ready", inPixelReady, 0);
`ifdef LBC_STATUS_EN
    chk("full_dropErr", dropErr, 1);
    chk("full_lineCount", lineCount, 4);
`endif

    // Continuous stream: three lines consumed while writing every cycle.
    do_reset();
    clear_counts();
    for (int i = 0; i < 3100; i++) cycle(1'b1, 1'b1);
    chk("stream_buf0", n_wrb[0], 2 * W);
    chk("stream_1101", n_rd1101, W);
    chk("stream_irq", n_int, 3);

    // Downstream stall of 10 cycles at read position 100.
    do_reset();
    clear_counts();
    for (int i = 0; i < 3 * W; i++) cycle(1'b1, 1'b1);
    guard = 0;
    while (n_pdv < 100 && guard < 2000) begin cycle(1'b0, 1'b1); guard++; end
    chk("stall_reach100", n_pdv, 100);
    pdv_before = n_pdv;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    chk("stall_no_pdv", n_pdv, pdv_before);
    guard = 0;
    while (n_int == 0 && guard < 1000) begin cycle(1'b0, 1'b1); guard++; end
    chk("stall_irq_seen", n_int, 1);
    chk("stall_total_pdv", n_pdv, W);

    // Reset in the middle of a read line.
    do_reset();
    clear_counts();
    for (int i = 0; i < 3 * W; i++) cycle(1'b1, 1'b1);
    guard = 0;
    while (n_pdv < 300 && guard < 2000) begin cycle(1'b0, 1'b1); guard++; end
    chk("midrst_reach300", n_pdv, 300);
    do_reset();
    clear_counts();
    for (int i = 0; i < 3 * W + 100; i++) cycle(1'b1, 1'b1);
    chk("midrst_buf0", n_wrb[0], W);
    chk("midrst_no_irq", n_int, 0);

    // Randomized traffic in phases with different input densities.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      int piv, posa;
      piv  = (ph == 2) ? 30 : ((ph == 3) ? 70 : 90);
      posa = (ph == 1) ? 30 : ((ph == 3) ? 70 : 90);
      for (int i = 0; i < 1500; i++)
        cycle(($urandom % 100) < piv, ($urandom % 100) < posa);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
